// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file widths and writeback request types
package rf_pkg;
  localparam int XLEN = 32;
  localparam int AW = 5;
  localparam int NREG = 2 ** AW;
  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0] word_t;
  typedef struct packed {
    reg_addr_t addr;
    word_t data;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, pointer advances only on a grant
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  logic [PW-1:0] last, nxt;
  logic found;
  int idx;
  always_comb begin
    gnt = '0;
    nxt = last;
    found = 1'b0;
    idx = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        nxt = PW'(idx);
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= PW'(N - 1);
    else if (|req) last <= nxt;
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the reg_file write port among writeback units and keeps a busy scoreboard.
// Optional write-stage forwarding ports under RF_WB_BYPASS_EN.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int XLEN = rf_pkg::XLEN,
  parameter int AW = rf_pkg::AW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*AW-1:0]   req_addr,
  input  logic [N_REQ*XLEN-1:0] req_data,
  input  logic                  claim_valid,
  input  logic [AW-1:0]         claim_addr,
  output logic [2**AW-1:0]      busy,
`ifdef RF_WB_BYPASS_EN
  input  logic [AW-1:0]         byp_ra1,
  input  logic [AW-1:0]         byp_ra2,
  input  logic [XLEN-1:0]       byp_rf_rd1,
  input  logic [XLEN-1:0]       byp_rf_rd2,
  output logic [XLEN-1:0]       byp_rd1,
  output logic [XLEN-1:0]       byp_rd2,
`endif
  output logic                  we3,
  output logic [AW-1:0]         wa3,
  output logic [XLEN-1:0]       wd3
);
  logic [N_REQ-1:0] gnt;
  logic [AW-1:0] sel_addr;
  logic [XLEN-1:0] sel_data;
  logic [2**AW-1:0] busy_n;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req_valid),
    .gnt  (gnt)
  );
  assign req_ready = gnt;
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*XLEN +: XLEN];
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else begin
      we3 <= |gnt && sel_addr != '0;
      if (|gnt) begin
        wa3 <= sel_addr;
        wd3 <= sel_data;
      end
    end
  // claim is applied after clear so a same-cycle reclaim keeps the register busy
  always_comb begin
    busy_n = busy;
    if (we3) busy_n[wa3] = 1'b0;
    if (claim_valid) busy_n[claim_addr] = 1'b1;
    busy_n[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else busy <= busy_n;
`ifdef RF_WB_BYPASS_EN
  assign byp_rd1 = (we3 && wa3 == byp_ra1 && wa3 != '0) ? wd3 : byp_rf_rd1;
  assign byp_rd2 = (we3 && wa3 == byp_ra2 && wa3 != '0) ? wd3 : byp_rf_rd2;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed checks of arbitration, write stage, scoreboard and optional bypass
module tb_rf_wb_arbiter;
  localparam int N = 3, XL = 32, A = 5, NR = 32;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*A-1:0] req_addr = '0;
  logic [N*XL-1:0] req_data = '0;
  logic claim_valid = 1'b0;
  logic [A-1:0] claim_addr = '0;
  logic [NR-1:0] busy;
  logic we3;
  logic [A-1:0] wa3;
  logic [XL-1:0] wd3;
`ifdef RF_WB_BYPASS_EN
  logic [A-1:0] byp_ra1 = '0, byp_ra2 = '0;
  logic [XL-1:0] byp_rf_rd1 = '0, byp_rf_rd2 = '0, byp_rd1, byp_rd2;
`endif
  int vec = 0, errs = 0;
  always #5 clk = ~clk;
  rf_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .claim_valid(claim_valid),
    .claim_addr(claim_addr), .busy(busy),
`ifdef RF_WB_BYPASS_EN
    .byp_ra1(byp_ra1), .byp_ra2(byp_ra2), .byp_rf_rd1(byp_rf_rd1),
    .byp_rf_rd2(byp_rf_rd2), .byp_rd1(byp_rd1), .byp_rd2(byp_rd2),
`endif
    .we3(we3), .wa3(wa3), .wd3(wd3)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    req_valid = '0;
    claim_valid = 1'b0;
    claim_addr = '0;
  endtask
  task automatic set_req(input int i, input logic [A-1:0] a, input logic [XL-1:0] d);
    req_valid[i] = 1'b1;
    req_addr[i*A +: A] = a;
    req_data[i*XL +: XL] = d;
  endtask
  task automatic test_reset;
    idle;
    #1;
    vec++; if (we3 !== 1'b0) begin errs++; $display("FAIL rst_we3: got %b want 0", we3); end
    vec++; if (busy !== '0) begin errs++; $display("FAIL rst_busy: got %h want 0", busy); end
    step;
    rst_n = 1'b1;
    claim_valid = 1'b1;
    claim_addr = 5'd6;
    set_req(1, 5'd4, 32'hCAFE0001);
    #1;
    vec++; if (req_ready !== 3'b010) begin errs++; $display("FAIL pre_ready: got %b want 010", req_ready); end
    step;
    idle;
    vec++; if (we3 !== 1'b1 || wa3 !== 5'd4 || wd3 !== 32'hCAFE0001) begin errs++; $display("FAIL pre_write: got %b/%h/%h want 1/04/cafe0001", we3, wa3, wd3); end
    vec++; if (busy !== 32'h40) begin errs++; $display("FAIL pre_busy: got %h want 00000040", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    vec++; if (we3 !== 1'b0 || wa3 !== '0 || wd3 !== '0) begin errs++; $display("FAIL mid_rst_write: got %b/%h/%h want 0/00/00000000", we3, wa3, wd3); end
    vec++; if (busy !== '0) begin errs++; $display("FAIL mid_rst_busy: got %h want 0", busy); end
    step;
    rst_n = 1'b1;
    req_valid = 3'b111;
    #1;
    vec++; if (req_ready !== 3'b001) begin errs++; $display("FAIL first_grant: got %b want 001", req_ready); end
    idle;
  endtask
  task automatic test_round_robin;
    logic [N-1:0] exp;
    for (int i = 0; i < N; i++) set_req(i, A'(i + 1), 32'h1000 + i);
    for (int k = 0; k < 6; k++) begin
      #1;
      exp = 3'b001 << (k % 3);
      vec++; if (req_ready !== exp) begin errs++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, exp); end
      step;
      vec++; if (we3 !== 1'b1 || wa3 !== A'(k % 3 + 1) || wd3 !== 32'h1000 + k % 3)
        begin errs++; $display("FAIL rr_write[%0d]: got %b/%h/%h want 1/%h/%h", k, we3, wa3, wd3, A'(k % 3 + 1), 32'h1000 + k % 3); end
    end
    idle;
  endtask
  task automatic test_scoreboard;
    claim_valid = 1'b1;
    claim_addr = 5'd5;
    step;
    idle;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) set_req(1, 5'd5, 32'hDEADBEEF);
      #1;
      vec++; if (busy[5] !== 1'b1) begin errs++; $display("FAIL sb_busy_c%0d: got %b want 1", c, busy[5]); end
      if (c == 3) begin
        vec++; if (req_ready !== 3'b010) begin errs++; $display("FAIL sb_ready: got %b want 010", req_ready); end
      end
      step;
    end
    idle;
    vec++; if (busy[5] !== 1'b1) begin errs++; $display("FAIL sb_busy_c4: got %b want 1", busy[5]); end
    vec++; if (we3 !== 1'b1 || wa3 !== 5'd5 || wd3 !== 32'hDEADBEEF) begin errs++; $display("FAIL sb_write: got %b/%h/%h want 1/05/deadbeef", we3, wa3, wd3); end
    step;
    vec++; if (busy[5] !== 1'b0 || we3 !== 1'b0) begin errs++; $display("FAIL sb_clear: got busy=%b we3=%b want 0/0", busy[5], we3); end
  endtask
  task automatic test_claim_clear;
    claim_valid = 1'b1;
    claim_addr = 5'd7;
    set_req(0, 5'd7, 32'h00000077);
    step;
    idle;
    claim_valid = 1'b1;
    claim_addr = 5'd7;
    #1;
    vec++; if (we3 !== 1'b1 || wa3 !== 5'd7 || busy[7] !== 1'b1) begin errs++; $display("FAIL cc_setup: got %b/%h/%b want 1/07/1", we3, wa3, busy[7]); end
    step;
    idle;
    vec++; if (busy[7] !== 1'b1) begin errs++; $display("FAIL cc_claim_wins: got %b want 1", busy[7]); end
    set_req(0, 5'd7, 32'h00000078);
    step;
    idle;
    step;
    vec++; if (busy[7] !== 1'b0) begin errs++; $display("FAIL cc_later_clear: got %b want 0", busy[7]); end
  endtask
  task automatic test_x0;
    set_req(2, 5'd0, 32'hFFFFFFFF);
    claim_valid = 1'b1;
    claim_addr = 5'd0;
    #1;
    vec++; if (req_ready !== 3'b100) begin errs++; $display("FAIL x0_ready: got %b want 100", req_ready); end
    step;
    idle;
    vec++; if (we3 !== 1'b0) begin errs++; $display("FAIL x0_we3: got %b want 0", we3); end
    vec++; if (busy !== '0) begin errs++; $display("FAIL x0_busy: got %h want 0", busy); end
  endtask
`ifdef RF_WB_BYPASS_EN
  task automatic test_bypass;
    set_req(0, 5'd9, 32'h12345678);
    step;
    idle;
    byp_ra1 = 5'd9;
    byp_ra2 = 5'd0;
    byp_rf_rd1 = 32'hAAAAAAAA;
    byp_rf_rd2 = 32'h55555555;
    #1;
    vec++; if (byp_rd1 !== 32'h12345678) begin errs++; $display("FAIL byp_rd1: got %h want 12345678", byp_rd1); end
    vec++; if (byp_rd2 !== 32'h55555555) begin errs++; $display("FAIL byp_rd2: got %h want 55555555", byp_rd2); end
    step;
    vec++; if (byp_rd1 !== 32'hAAAAAAAA) begin errs++; $display("FAIL byp_idle: got %h want aaaaaaaa", byp_rd1); end
  endtask
`endif
  initial begin
    test_reset;
    test_round_robin;
    test_scoreboard;
    test_claim_clear;
    test_x0;
`ifdef RF_WB_BYPASS_EN
    test_bypass;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
